// File: rtl/decode_pipe_pkg.sv
// Shared decode definitions: control record, branch ops, source-mux encodings
// and the combinational decode helpers (control, immediate, branch compare).
package decode_pipe_pkg;

  localparam int DP_XLEN = 32;
  localparam int DP_REGW = 6;

  // ALU source-0 select encodings (2'b11 also yields zero)
  localparam logic [1:0] SRC0_RS   = 2'b00;
  localparam logic [1:0] SRC0_ZERO = 2'b01;
  localparam logic [1:0] SRC0_PC   = 2'b10;

  // ALU source-1 select encodings (2'b11 yields zero)
  localparam logic [1:0] SRC1_RS   = 2'b00;
  localparam logic [1:0] SRC1_FOUR = 2'b01;
  localparam logic [1:0] SRC1_IMM  = 2'b10;
  localparam logic [1:0] SRC1_ZERO = 2'b11;

  // Integer x0: never forwarded, always read from the register file
  localparam logic [DP_REGW-1:0] REG_ZERO = '0;

  typedef enum logic [2:0] {
    BR_NONE, BR_EQ, BR_NE, BR_LT, BR_GE, BR_LTU, BR_GEU
  } branchop_t;

  typedef enum logic [2:0] {
    IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
  } immsel_t;

  typedef struct packed {
    logic      regwrite;
    logic      memread;
    logic      memwrite;
    logic      jump;
    logic [1:0] src0sel;
    logic [1:0] src1sel;
    branchop_t branchop;
    immsel_t   immsel;
    logic [2:0] funct3;
    logic      funct7b5;
    logic      fp_rs0;
    logic      fp_rs1;
    logic      fp_rd;
  } ctrl_t;

  // Decoded instruction record handed to execute
  typedef struct packed {
    logic [DP_XLEN-1:0] pc;
    logic [DP_REGW-1:0] rs0;
    logic [DP_REGW-1:0] rs1;
    logic [DP_REGW-1:0] rd;
    logic [DP_XLEN-1:0] imm;
    ctrl_t              ctrl;
  } Inst;

  // Main control decode by opcode; fp flags mark which indices are FP registers
  function automatic ctrl_t single_cycle_control(input logic [31:0] instr);
    ctrl_t c;
    c          = '0;
    c.branchop = BR_NONE;
    c.immsel   = IMM_NONE;
    c.src0sel  = SRC0_ZERO;
    c.src1sel  = SRC1_ZERO;
    c.funct3   = instr[14:12];
    c.funct7b5 = instr[30];
    case (instr[6:0])
      7'b0110011: begin c.src0sel = SRC0_RS; c.src1sel = SRC1_RS;  c.regwrite = 1'b1; end
      7'b0010011: begin c.src0sel = SRC0_RS; c.src1sel = SRC1_IMM; c.regwrite = 1'b1; c.immsel = IMM_I; end
      7'b0000011: begin c.src0sel = SRC0_RS; c.src1sel = SRC1_IMM; c.regwrite = 1'b1; c.memread = 1'b1; c.immsel = IMM_I; end
      7'b0000111: begin c.src0sel = SRC0_RS; c.src1sel = SRC1_IMM; c.regwrite = 1'b1; c.memread = 1'b1; c.immsel = IMM_I; c.fp_rd = 1'b1; end
      7'b0100011: begin c.src0sel = SRC0_RS; c.src1sel = SRC1_IMM; c.memwrite = 1'b1; c.immsel = IMM_S; end
      7'b0100111: begin c.src0sel = SRC0_RS; c.src1sel = SRC1_IMM; c.memwrite = 1'b1; c.immsel = IMM_S; c.fp_rs1 = 1'b1; end
      7'b1010011: begin c.src0sel = SRC0_RS; c.src1sel = SRC1_RS; c.regwrite = 1'b1;
                        c.fp_rs0 = 1'b1; c.fp_rs1 = 1'b1; c.fp_rd = 1'b1; end
      7'b1100011: begin
        c.src0sel = SRC0_PC; c.src1sel = SRC1_IMM; c.immsel = IMM_B;
        case (instr[14:12])
          3'b000:  c.branchop = BR_EQ;
          3'b001:  c.branchop = BR_NE;
          3'b100:  c.branchop = BR_LT;
          3'b101:  c.branchop = BR_GE;
          3'b110:  c.branchop = BR_LTU;
          3'b111:  c.branchop = BR_GEU;
          default: c.branchop = BR_NONE;
        endcase
      end
      7'b1101111: begin c.src0sel = SRC0_PC;   c.src1sel = SRC1_FOUR; c.regwrite = 1'b1; c.jump = 1'b1; c.immsel = IMM_J; end
      7'b1100111: begin c.src0sel = SRC0_PC;   c.src1sel = SRC1_FOUR; c.regwrite = 1'b1; c.jump = 1'b1; c.immsel = IMM_I; end
      7'b0110111: begin c.src0sel = SRC0_ZERO; c.src1sel = SRC1_IMM;  c.regwrite = 1'b1; c.immsel = IMM_U; end
      7'b0010111: begin c.src0sel = SRC0_PC;   c.src1sel = SRC1_IMM;  c.regwrite = 1'b1; c.immsel = IMM_U; end
      default: ;
    endcase
    return c;
  endfunction

  // Sign-extended immediate for the selected instruction format
  function automatic logic [DP_XLEN-1:0] immgen(input logic [31:0] i, input immsel_t sel);
    logic [DP_XLEN-1:0] imm;
    case (sel)
      IMM_I:   imm = {{20{i[31]}}, i[31:20]};
      IMM_S:   imm = {{20{i[31]}}, i[31:25], i[11:7]};
      IMM_B:   imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      IMM_U:   imm = {i[31:12], 12'b0};
      IMM_J:   imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

  // Branch condition on the forwarded operands
  function automatic logic branch_unit(input branchop_t op, input logic [DP_XLEN-1:0] a,
                                       input logic [DP_XLEN-1:0] b);
    logic taken;
    case (op)
      BR_EQ:   taken = (a == b);
      BR_NE:   taken = (a != b);
      BR_LT:   taken = ($signed(a) <  $signed(b));
      BR_GE:   taken = ($signed(a) >= $signed(b));
      BR_LTU:  taken = (a <  b);
      BR_GEU:  taken = (a >= b);
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/decode_pipe_fwd_select.sv
// Priority forwarding mux for one operand: the lowest-index matching source wins,
// and pending reports that the winning source has not produced its result yet.
module decode_pipe_fwd_select
  import decode_pipe_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int REGW = 6,
  parameter int NFWD = 2
) (
  input  logic [REGW-1:0]      rs,
  input  logic [XLEN-1:0]      rfdata,
  input  logic [NFWD-1:0]      fwd_valid,
  input  logic [NFWD*REGW-1:0] fwd_rd,
  input  logic [NFWD*XLEN-1:0] fwd_data,
  input  logic [NFWD-1:0]      fwd_avail,
  output logic [XLEN-1:0]      data,
  output logic                 pending
);

  logic [NFWD-1:0] hit;

  genvar gi;
  generate
    for (gi = 0; gi < NFWD; gi++) begin : g_match
      assign hit[gi] = fwd_valid[gi] && (fwd_rd[gi*REGW +: REGW] == rs) && (rs != REG_ZERO);
    end
  endgenerate

  // Walk from oldest to youngest so the lowest matching index overrides
  always_comb begin
    data    = rfdata;
    pending = 1'b0;
    for (int i = NFWD - 1; i >= 0; i--) begin
      if (hit[i]) begin
        data    = fwd_data[i*XLEN +: XLEN];
        pending = !fwd_avail[i];
      end
    end
  end

endmodule

// File: rtl/decode_pipe.sv
// Registered decode stage between fetch and execute: decode, operand forwarding,
// load-use stall, early branch resolution, valid/ready output register.
module decode_pipe
  import decode_pipe_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int REGW = 6,
  parameter int NFWD = 2,
  parameter int CNTW = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [XLEN-1:0]      in_pc,
  input  logic [31:0]          in_instr,
  output logic [REGW-1:0]      rs0,
  output logic [REGW-1:0]      rs1,
  input  logic [XLEN-1:0]      rs0data,
  input  logic [XLEN-1:0]      rs1data,
  input  logic [NFWD-1:0]      fwd_valid,
  input  logic [NFWD*REGW-1:0] fwd_rd,
  input  logic [NFWD*XLEN-1:0] fwd_data,
  input  logic [NFWD-1:0]      fwd_avail,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output Inst                  out_inst,
  output logic [XLEN-1:0]      out_rdata0,
  output logic [XLEN-1:0]      out_rdata1,
  output logic [XLEN-1:0]      out_src0,
  output logic [XLEN-1:0]      out_src1,
  output logic                 out_brflag,
  output logic [CNTW-1:0]      stall_cnt
);

  ctrl_t           ctrl;
  Inst             dec;
  logic [XLEN-1:0] rdata0, rdata1, src0, src1;
  logic            pend0, pend1, hazard, accept, brflag;

  Inst             inst_reg;
  logic            out_valid_reg;
  logic [XLEN-1:0] rdata0_reg, rdata1_reg, src0_reg, src1_reg;
  logic            brflag_reg;
  logic [CNTW-1:0] stall_cnt_reg;

  // Decode the presented instruction into the shared record
  always_comb begin
    ctrl     = single_cycle_control(in_instr);
    dec      = '0;
    dec.pc   = in_pc;
    dec.rs0  = {ctrl.fp_rs0, in_instr[19:15]};
    dec.rs1  = {ctrl.fp_rs1, in_instr[24:20]};
    dec.rd   = {ctrl.fp_rd,  in_instr[11:7]};
    dec.imm  = immgen(in_instr, ctrl.immsel);
    dec.ctrl = ctrl;
  end

  assign rs0 = dec.rs0;
  assign rs1 = dec.rs1;

  decode_pipe_fwd_select #(.XLEN(XLEN), .REGW(REGW), .NFWD(NFWD)) u_fwd0 (
    .rs(rs0), .rfdata(rs0data), .fwd_valid(fwd_valid), .fwd_rd(fwd_rd),
    .fwd_data(fwd_data), .fwd_avail(fwd_avail), .data(rdata0), .pending(pend0)
  );

  decode_pipe_fwd_select #(.XLEN(XLEN), .REGW(REGW), .NFWD(NFWD)) u_fwd1 (
    .rs(rs1), .rfdata(rs1data), .fwd_valid(fwd_valid), .fwd_rd(fwd_rd),
    .fwd_data(fwd_data), .fwd_avail(fwd_avail), .data(rdata1), .pending(pend1)
  );

  // ALU source muxes; unused encodings select zero
  always_comb begin
    case (ctrl.src0sel)
      SRC0_RS: src0 = rdata0;
      SRC0_PC: src0 = in_pc;
      default: src0 = '0;
    endcase
    case (ctrl.src1sel)
      SRC1_RS:   src1 = rdata1;
      SRC1_FOUR: src1 = XLEN'(4);
      SRC1_IMM:  src1 = dec.imm;
      default:   src1 = '0;
    endcase
  end

  assign brflag   = branch_unit(ctrl.branchop, rdata0, rdata1);
  // Both operands stall on a pending source even if the instruction ignores one
  assign hazard   = in_valid && (pend0 || pend1);
  assign in_ready = rstn && !flush && !hazard && (!out_valid_reg || out_ready);
  assign accept   = in_valid && in_ready;

  // Output pipeline register: flush kills, accept loads, drained entry clears
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid_reg <= 1'b0;
      inst_reg      <= '0;
      rdata0_reg    <= '0;
      rdata1_reg    <= '0;
      src0_reg      <= '0;
      src1_reg      <= '0;
      brflag_reg    <= 1'b0;
    end else if (flush) begin
      out_valid_reg <= 1'b0;
    end else if (accept) begin
      out_valid_reg <= 1'b1;
      inst_reg      <= dec;
      rdata0_reg    <= rdata0;
      rdata1_reg    <= rdata1;
      src0_reg      <= src0;
      src1_reg      <= src1;
      brflag_reg    <= brflag;
    end else if (out_valid_reg && out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  // Saturating count of cycles lost to load-use hazards (flush cycles excluded)
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_cnt_reg <= '0;
    end else if (hazard && !flush && (stall_cnt_reg != '1)) begin
      stall_cnt_reg <= stall_cnt_reg + CNTW'(1);
    end
  end

  assign out_valid  = out_valid_reg;
  assign out_inst   = inst_reg;
  assign out_rdata0 = rdata0_reg;
  assign out_rdata1 = rdata1_reg;
  assign out_src0   = src0_reg;
  assign out_src1   = src1_reg;
  assign out_brflag = brflag_reg;
  assign stall_cnt  = stall_cnt_reg;

endmodule

// File: tb/tb_decode_pipe.sv
// Directed bench for decode_pipe: reset, forwarding priority, load-use stall,
// backpressure, flush, counter saturation, branch resolution, async reset.
module tb_decode_pipe;
  import decode_pipe_pkg::*;

  localparam int XLEN = 32;
  localparam int REGW = 6;
  localparam int NFWD = 2;
  localparam int CNTW = 4;

  localparam logic [31:0] I_ADDI = 32'h00500093; // addi x1,x0,5
  localparam logic [31:0] I_ADD  = 32'h004182B3; // add  x5,x3,x4
  localparam logic [31:0] I_BLT8 = 32'h0020C463; // blt  x1,x2,+8
  localparam logic [31:0] I_BLT  = 32'h0020C063; // blt  x1,x2,0
  localparam logic [31:0] I_BGE  = 32'h0020D063; // bge  x1,x2,0
  localparam logic [31:0] I_BLTU = 32'h0020E063; // bltu x1,x2,0

  logic                 clk = 1'b0;
  logic                 rstn;
  logic                 in_valid, in_ready;
  logic [XLEN-1:0]      in_pc;
  logic [31:0]          in_instr;
  logic [REGW-1:0]      rs0, rs1;
  logic [XLEN-1:0]      rs0data, rs1data;
  logic [NFWD-1:0]      fwd_valid, fwd_avail;
  logic [NFWD*REGW-1:0] fwd_rd;
  logic [NFWD*XLEN-1:0] fwd_data;
  logic                 flush, out_valid, out_ready, out_brflag;
  Inst                  out_inst;
  logic [XLEN-1:0]      out_rdata0, out_rdata1, out_src0, out_src1;
  logic [CNTW-1:0]      stall_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // Register file stand-in: x0 reads zero, others read 0x1000 + index
  always_comb begin
    rs0data = (rs0 == '0) ? '0 : 32'h1000 + XLEN'(rs0);
    rs1data = (rs1 == '0) ? '0 : 32'h1000 + XLEN'(rs1);
  end

  decode_pipe #(.XLEN(XLEN), .REGW(REGW), .NFWD(NFWD), .CNTW(CNTW)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_instr(in_instr), .rs0(rs0), .rs1(rs1),
    .rs0data(rs0data), .rs1data(rs1data), .fwd_valid(fwd_valid), .fwd_rd(fwd_rd),
    .fwd_data(fwd_data), .fwd_avail(fwd_avail), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_rdata0(out_rdata0), .out_rdata1(out_rdata1), .out_src0(out_src0),
    .out_src1(out_src1), .out_brflag(out_brflag), .stall_cnt(stall_cnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("t=%0t %s observed=%0h expected=%0h", $time, tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  initial begin
    rstn = 1'b0; in_valid = 1'b0; in_pc = '0; in_instr = '0;
    fwd_valid = '0; fwd_rd = '0; fwd_data = '0; fwd_avail = '0;
    flush = 1'b0; out_ready = 1'b0;

    // Reset state
    tick;
    check("rst_in_ready",  64'(in_ready),  64'h0);
    check("rst_out_valid", 64'(out_valid), 64'h0);
    check("rst_stall_cnt", 64'(stall_cnt), 64'h0);
    check("rst_src0",      64'(out_src0),  64'h0);
    rstn = 1'b1;
    tick;

    // ADDI x1,x0,5 at pc 0x100
    in_valid = 1'b1; in_pc = 32'h100; in_instr = I_ADDI; out_ready = 1'b1;
    settle;
    check("addi_in_ready", 64'(in_ready), 64'h1);
    tick;
    check("addi_valid", 64'(out_valid),   64'h1);
    check("addi_src0",  64'(out_src0),    64'h0);
    check("addi_src1",  64'(out_src1),    64'h5);
    check("addi_pc",    64'(out_inst.pc), 64'h100);
    check("addi_rd",    64'(out_inst.rd), 64'h1);

    // Both sources match x3: source 0 wins
    in_pc = 32'h104; in_instr = I_ADD;
    fwd_valid = 2'b11; fwd_rd = {6'd3, 6'd3}; fwd_data = {32'hBB, 32'hAA}; fwd_avail = 2'b11;
    tick;
    check("fwd_both_rdata0", 64'(out_rdata0), 64'hAA);
    check("fwd_both_rdata1", 64'(out_rdata1), 64'h1004);
    check("fwd_both_src1",   64'(out_src1),   64'h1004);

    // Only source 1 valid
    in_pc = 32'h108; fwd_valid = 2'b10;
    tick;
    check("fwd_src1_rdata0", 64'(out_rdata0), 64'hBB);

    // Source 0 feeds rs0, source 1 feeds rs1
    in_pc = 32'h10C; fwd_valid = 2'b11; fwd_rd = {6'd4, 6'd3};
    tick;
    check("fwd_split_rdata0", 64'(out_rdata0), 64'hAA);
    check("fwd_split_rdata1", 64'(out_rdata1), 64'hBB);
    check("fwd_split_pc",     64'(out_inst.pc), 64'h10C);

    // Load-use: source 0 pending on x3 for three cycles
    in_pc = 32'h110; fwd_valid = 2'b01; fwd_rd = {6'd0, 6'd3}; fwd_avail = 2'b00;
    for (int k = 0; k < 3; k++) begin
      settle;
      check("stall_in_ready", 64'(in_ready), 64'h0);
      tick;
      check("stall_out_valid", 64'(out_valid), 64'h0);
    end
    check("stall_cnt_3", 64'(stall_cnt), 64'h3);
    fwd_avail = 2'b01; fwd_data = {32'hBB, 32'hCC};
    settle;
    check("unstall_in_ready", 64'(in_ready), 64'h1);
    tick;
    check("unstall_valid",  64'(out_valid),   64'h1);
    check("unstall_pc",     64'(out_inst.pc), 64'h110);
    check("unstall_rdata0", 64'(out_rdata0),  64'hCC);
    in_valid = 1'b0;
    tick;
    check("unstall_once", 64'(out_valid), 64'h0);
    check("stall_cnt_hold", 64'(stall_cnt), 64'h3);

    // Youngest match pending, older avail: still stalls
    in_valid = 1'b1; in_pc = 32'h114;
    fwd_valid = 2'b11; fwd_rd = {6'd3, 6'd3}; fwd_avail = 2'b10; fwd_data = {32'hDD, 32'hEE};
    settle;
    check("young_pend_in_ready", 64'(in_ready), 64'h0);
    tick;
    check("young_pend_cnt",   64'(stall_cnt), 64'h4);
    check("young_pend_valid", 64'(out_valid), 64'h0);

    // Backpressure: hold outputs for five cycles
    fwd_valid = 2'b00; in_pc = 32'h118; in_instr = I_ADDI;
    tick;
    check("bp_first_pc", 64'(out_inst.pc), 64'h118);
    out_ready = 1'b0; in_pc = 32'h11C;
    for (int k = 0; k < 5; k++) begin
      settle;
      check("bp_in_ready", 64'(in_ready), 64'h0);
      tick;
      check("bp_valid", 64'(out_valid),   64'h1);
      check("bp_pc",    64'(out_inst.pc), 64'h118);
    end
    out_ready = 1'b1;
    settle;
    check("bp_release_in_ready", 64'(in_ready), 64'h1);
    tick;
    check("bp_next_valid", 64'(out_valid),   64'h1);
    check("bp_next_pc",    64'(out_inst.pc), 64'h11C);
    in_valid = 1'b0;
    tick;
    check("bp_no_dup", 64'(out_valid), 64'h0);

    // Flush with a live entry and a hazard present
    in_valid = 1'b1; in_pc = 32'h120;
    tick;
    check("pre_flush_valid", 64'(out_valid), 64'h1);
    out_ready = 1'b0; flush = 1'b1; in_pc = 32'h124; in_instr = I_ADD;
    fwd_valid = 2'b01; fwd_rd = {6'd0, 6'd3}; fwd_avail = 2'b00;
    settle;
    check("flush_in_ready", 64'(in_ready), 64'h0);
    tick;
    check("flush_valid", 64'(out_valid), 64'h0);
    check("flush_cnt",   64'(stall_cnt), 64'h4);

    // Counter saturation: 11 more stalls reach 15, then it holds
    flush = 1'b0; out_ready = 1'b1;
    repeat (11) tick;
    check("sat_cnt_15", 64'(stall_cnt), 64'hF);
    repeat (2) tick;
    check("sat_cnt_hold", 64'(stall_cnt), 64'hF);

    // Branches: rdata0 from source 0 (x1), rdata1 from source 1 (x2)
    fwd_valid = 2'b11; fwd_avail = 2'b11; fwd_rd = {6'd2, 6'd1};
    fwd_data = {32'h00000001, 32'hFFFFFFFF};
    in_pc = 32'h200; in_instr = I_BLT8;
    tick;
    check("blt_flag",  64'(out_brflag),            64'h1);
    check("blt_op",    64'(out_inst.ctrl.branchop), 64'(BR_LT));
    check("blt_src0",  64'(out_src0),              64'h200);
    check("blt_src1",  64'(out_src1),              64'h8);
    fwd_data = {32'hFFFFFFFF, 32'h00000001}; in_instr = I_BLT;
    tick;
    check("blt_swap_flag", 64'(out_brflag), 64'h0);
    in_instr = I_BGE;
    tick;
    check("bge_flag", 64'(out_brflag), 64'h1);
    in_instr = I_BLTU;
    tick;
    check("bltu_flag", 64'(out_brflag), 64'h1);
    fwd_data = {32'h00000001, 32'hFFFFFFFF}; in_instr = I_BLT;
    tick;
    check("blt_again_flag", 64'(out_brflag), 64'h1);

    // Asynchronous reset mid-cycle clears everything at once
    #2;
    rstn = 1'b0;
    #1;
    check("arst_valid",    64'(out_valid),  64'h0);
    check("arst_brflag",   64'(out_brflag), 64'h0);
    check("arst_src0",     64'(out_src0),   64'h0);
    check("arst_rdata0",   64'(out_rdata0), 64'h0);
    check("arst_cnt",      64'(stall_cnt),  64'h0);
    check("arst_in_ready", 64'(in_ready),   64'h0);
    check("arst_inst",     64'(out_inst === '0), 64'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
